// File: rtl/mux_scan_n.sv
// Registered N:1 channel mux: direct select by S, or a dwell-timed scan of all channels.
// One cycle from D/S to Y; no backpressure, valid pulses once per captured sample.
module mux_scan_n #(
    parameter int N  = 16,
    parameter int W  = 8,
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  D,
    input  logic [$clog2(N)-1:0] S,
    input  logic            mode,
    input  logic            en,
    input  logic [DW-1:0]   dwell,
    output logic [W-1:0]    Y,
    output logic [$clog2(N)-1:0] ch,
    output logic            valid,
    output logic            wrap
);
    localparam int SW = $clog2(N);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    state_t        r_state;
    logic [W-1:0]  r_y;
    logic [SW-1:0] r_ch;
    logic          r_valid;
    logic          r_wrap;
    logic [SW-1:0] r_ch_cnt;
    logic [DW-1:0] r_dwell_cnt;

    state_t        w_state_nxt;
    logic [SW-1:0] w_ch_cur;
    logic [DW-1:0] w_dcnt_cur;
    logic [SW-1:0] w_sel;
    logic [W-1:0]  w_d_sel;
    logic [W-1:0]  w_y_nxt;
    logic [SW-1:0] w_ch_nxt;
    logic          w_valid_nxt;
    logic          w_wrap_nxt;
    logic [SW-1:0] w_ch_cnt_nxt;
    logic [DW-1:0] w_dwell_cnt_nxt;

    always_comb begin
        w_state_nxt     = ST_IDLE;
        w_ch_cur        = '0;
        w_dcnt_cur      = '0;
        w_sel           = S;
        w_d_sel         = '0;
        w_y_nxt         = r_y;
        w_ch_nxt        = r_ch;
        w_valid_nxt     = 1'b0;
        w_wrap_nxt      = 1'b0;
        w_ch_cnt_nxt    = '0;
        w_dwell_cnt_nxt = '0;

        if (en) begin
            w_state_nxt = mode ? ST_SCAN : ST_DIRECT;
        end

        // Counters read as zero on the edge that enters SCAN, whatever came before.
        if (r_state == ST_SCAN) begin
            w_ch_cur   = r_ch_cnt;
            w_dcnt_cur = r_dwell_cnt;
        end

        if (w_state_nxt == ST_SCAN) begin
            w_sel = w_ch_cur;
        end
        w_d_sel = D[int'(w_sel)*W +: W];

        case (w_state_nxt)
            ST_DIRECT: begin
                w_y_nxt     = w_d_sel;
                w_ch_nxt    = S;
                w_valid_nxt = 1'b1;
            end
            ST_SCAN: begin
                if (w_dcnt_cur >= dwell) begin
                    w_y_nxt      = w_d_sel;
                    w_ch_nxt     = w_ch_cur;
                    w_valid_nxt  = 1'b1;
                    w_wrap_nxt   = (w_ch_cur == SW'(N-1));
                    w_ch_cnt_nxt = w_ch_cur + 1'b1;
                end else begin
                    w_ch_cnt_nxt    = w_ch_cur;
                    w_dwell_cnt_nxt = w_dcnt_cur + 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_y         <= '0;
            r_ch        <= '0;
            r_valid     <= 1'b0;
            r_wrap      <= 1'b0;
            r_ch_cnt    <= '0;
            r_dwell_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_y         <= w_y_nxt;
            r_ch        <= w_ch_nxt;
            r_valid     <= w_valid_nxt;
            r_wrap      <= w_wrap_nxt;
            r_ch_cnt    <= w_ch_cnt_nxt;
            r_dwell_cnt <= w_dwell_cnt_nxt;
        end
    end

    assign Y     = r_y;
    assign ch    = r_ch;
    assign valid = r_valid;
    assign wrap  = r_wrap;
endmodule

// File: tb/tb_mux_scan_n.sv
// Directed bench for mux_scan_n with N=16, W=8; channel k carries 8'h10+k.
module tb_mux_scan_n;
    localparam int N  = 16;
    localparam int W  = 8;
    localparam int DW = 8;
    localparam int SW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*W-1:0]  D;
    logic [SW-1:0]   S = '0;
    logic            mode = 1'b0;
    logic            en = 1'b0;
    logic [DW-1:0]   dwell = '0;
    logic [W-1:0]    Y;
    logic [SW-1:0]   ch;
    logic            valid;
    logic            wrap;

    int checks = 0;
    int errors = 0;

    mux_scan_n #(.N(N), .W(W), .DW(DW)) dut (
        .clk(clk), .rst(rst), .D(D), .S(S), .mode(mode), .en(en),
        .dwell(dwell), .Y(Y), .ch(ch), .valid(valid), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [W-1:0] ey, input logic [SW-1:0] ec,
                           input logic ev, input logic ew);
        chk({tag, ".Y"}, 32'(Y), 32'(ey));
        chk({tag, ".ch"}, 32'(ch), 32'(ec));
        chk({tag, ".valid"}, 32'(valid), 32'(ev));
        chk({tag, ".wrap"}, 32'(wrap), 32'(ew));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0]  ey;
        logic [SW-1:0] ec;
        for (int k = 0; k < N; k++) D[k*W +: W] = 8'h10 + 8'(k);

        #2;
        chk_out("reset", 8'h00, 4'd0, 1'b0, 1'b0);
        step();
        chk_out("reset_clk", 8'h00, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        chk_out("idle_after_rst", 8'h00, 4'd0, 1'b0, 1'b0);

        // Direct mode
        en = 1'b1; mode = 1'b0; S = 4'd5;
        step();
        chk_out("direct_s5", 8'h15, 4'd5, 1'b1, 1'b0);
        S = 4'd15;
        step();
        chk_out("direct_s15", 8'h1F, 4'd15, 1'b1, 1'b0);

        // Scan, dwell=0, S scrambled to show it is ignored
        mode = 1'b1; dwell = 8'd0;
        for (int i = 0; i < 18; i++) begin
            S = 4'($urandom_range(0, 15));
            step();
            ec = 4'(i % 16);
            chk_out("scan_d0", 8'h10 + 8'(ec), ec, 1'b1, ec == 4'd15);
        end

        en = 1'b0;
        step();
        chk_out("idle_hold", 8'h11, 4'd1, 1'b0, 1'b0);

        // Scan, dwell=2: capture on every 3rd edge
        en = 1'b1; mode = 1'b1; dwell = 8'd2;
        ey = 8'h11; ec = 4'd1;
        for (int e = 1; e <= 9; e++) begin
            step();
            if (e % 3 == 0) begin
                ec = 4'(e / 3 - 1);
                ey = 8'h10 + 8'(ec);
                chk_out("scan_d2_cap", ey, ec, 1'b1, 1'b0);
            end else begin
                chk_out("scan_d2_hold", ey, ec, 1'b0, 1'b0);
            end
        end

        // Scan, dwell=5 reduced to 1 once dwell_cnt reaches 3
        en = 1'b0;
        step();
        en = 1'b1; dwell = 8'd5;
        for (int e = 1; e <= 3; e++) begin
            step();
            chk_out("scan_d5_hold", 8'h12, 4'd2, 1'b0, 1'b0);
        end
        dwell = 8'd1;
        step();
        chk_out("scan_d1_first", 8'h10, 4'd0, 1'b1, 1'b0);
        step();
        chk_out("scan_d1_gap", 8'h10, 4'd0, 1'b0, 1'b0);
        step();
        chk_out("scan_d1_second", 8'h11, 4'd1, 1'b1, 1'b0);
        step();
        step();
        chk_out("scan_d1_third", 8'h12, 4'd2, 1'b1, 1'b0);

        // Drop en at channel 7, then resume scan from channel 0
        en = 1'b0;
        step();
        en = 1'b1; dwell = 8'd0;
        for (int i = 0; i < 8; i++) step();
        chk_out("scan_ch7", 8'h17, 4'd7, 1'b1, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("en_low_hold", 8'h17, 4'd7, 1'b0, 1'b0);
        end
        en = 1'b1;
        step();
        chk_out("rescan_ch0", 8'h10, 4'd0, 1'b1, 1'b0);
        step();
        step();

        // SCAN -> DIRECT -> SCAN restarts at channel 0
        mode = 1'b0; S = 4'd3;
        step();
        chk_out("scan_to_direct", 8'h13, 4'd3, 1'b1, 1'b0);
        mode = 1'b1;
        step();
        chk_out("direct_to_scan", 8'h10, 4'd0, 1'b1, 1'b0);
        step();
        chk_out("direct_to_scan2", 8'h11, 4'd1, 1'b1, 1'b0);

        // Asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        chk_out("async_rst", 8'h00, 4'd0, 1'b0, 1'b0);
        en = 1'b0;
        step();
        #2;
        rst = 1'b0;
        step();
        chk_out("post_rst_idle", 8'h00, 4'd0, 1'b0, 1'b0);
        step();
        chk_out("post_rst_idle2", 8'h00, 4'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
